// File: rtl/multicycle_control.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB over an internal
// instruction register and decodes the datapath strobes from state and IR.
module multicycle_control #(
    parameter int unsigned INSTR_W     = 32,
    parameter int unsigned ALU_OP_W    = 4,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INSTR_W-1:0]  instr,
    input  logic                instr_ready,
    input  logic                mem_ready,
    output logic                instr_req,
    output logic                ir_write,
    output logic                pc_write,
    output logic                reg_dst,
    output logic                jump,
    output logic                branch,
    output logic                mem_read,
    output logic                mem_to_reg,
    output logic                mem_write,
    output logic                alu_src,
    output logic                reg_write,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal_op,
    output logic                mem_err,
    output logic                retire,
    output logic [2:0]          state_dbg
);

    localparam int unsigned OPC_W = 6;
    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001110;
    localparam logic [OPC_W-1:0] OP_PASSI = 6'b001111;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100100;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b100110;
    localparam logic [OPC_W-1:0] OP_BR    = 6'b001100;
    localparam logic [OPC_W-1:0] OP_JUMP  = 6'b000100;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [INSTR_W-1:0] r_ir;
    logic [CNT_W-1:0]   r_cnt;
    logic [OPC_W-1:0]   w_opcode;
    logic               w_is_lw;
    logic               w_is_sw;
    logic               w_legal;
    logic               w_timeout;
    logic               w_unused;

    assign w_opcode  = r_ir[INSTR_W-1 -: OPC_W];
    assign w_is_lw   = (w_opcode == OP_LW);
    assign w_is_sw   = (w_opcode == OP_SW);
    assign w_legal   = (w_opcode == OP_RTYPE) || (w_opcode == OP_ADDI) ||
                       (w_opcode == OP_PASSI) || w_is_lw || w_is_sw ||
                       (w_opcode == OP_BR)    || (w_opcode == OP_JUMP);
    assign w_timeout = (r_cnt == CNT_W'(MEM_TIMEOUT - 1));
    assign w_unused  = ^r_ir[INSTR_W-OPC_W-1:ALU_OP_W];
    assign state_dbg = r_state;

    // State, instruction register and MEM wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && instr_ready) begin
                r_ir <= instr;
            end
            // Cleared outside MEM so each MEM entry starts from zero
            r_cnt <= (r_state == S_MEM && !mem_ready) ? r_cnt + CNT_W'(1) : '0;
        end
    end

    always_comb begin
        w_next     = r_state;
        instr_req  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_dst    = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        mem_read   = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        alu_op     = '0;
        illegal_op = 1'b0;
        mem_err    = 1'b0;
        retire     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                instr_req = 1'b1;
                if (instr_ready) begin
                    ir_write = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_next = S_EXEC;
                end else begin
                    illegal_op = 1'b1;
                    pc_write   = 1'b1;
                    w_next     = S_FETCH;
                end
            end
            S_EXEC: begin
                w_next = S_FETCH;
                case (w_opcode)
                    OP_RTYPE: begin
                        alu_op  = r_ir[ALU_OP_W-1:0];
                        reg_dst = 1'b1;
                        w_next  = S_WB;
                    end
                    OP_ADDI: begin
                        alu_op  = ALU_OP_W'(2);
                        alu_src = 1'b1;
                        w_next  = S_WB;
                    end
                    OP_PASSI: begin
                        alu_src = 1'b1;
                        w_next  = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_op  = ALU_OP_W'(2);
                        alu_src = 1'b1;
                        w_next  = S_MEM;
                    end
                    OP_BR: begin
                        alu_op   = ALU_OP_W'(6);
                        branch   = 1'b1;
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                    OP_JUMP: begin
                        jump     = 1'b1;
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                    default: begin
                        w_next = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                alu_op    = ALU_OP_W'(2);
                alu_src   = 1'b1;
                mem_read  = w_is_lw;
                mem_write = w_is_sw;
                // A late mem_ready still beats the timeout in the same cycle
                if (mem_ready) begin
                    if (w_is_lw) begin
                        w_next = S_WB;
                    end else begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        w_next   = S_FETCH;
                    end
                end else if (w_timeout) begin
                    mem_err  = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                retire     = 1'b1;
                reg_dst    = (w_opcode == OP_RTYPE);
                mem_to_reg = w_is_lw;
                w_next     = S_FETCH;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected output traces built from
// the opcode table and handshake delays, compared every cycle.
module tb_multicycle_control;

    localparam int unsigned MEM_TIMEOUT = 15;

    typedef struct packed {
        logic       instr_req;
        logic       ir_write;
        logic       pc_write;
        logic       reg_dst;
        logic       jump;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [3:0] alu_op;
        logic       illegal_op;
        logic       mem_err;
        logic       retire;
        logic [2:0] state;
    } vec_t;

    typedef struct {
        vec_t        exp;
        logic        rdy;
        logic        mrdy;
        logic [31:0] ins;
    } step_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_ready;
    logic        mem_ready;
    logic        instr_req, ir_write, pc_write, reg_dst, jump, branch;
    logic        mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic [3:0]  alu_op;
    logic        illegal_op, mem_err, retire;
    logic [2:0]  state_dbg;
    vec_t        obs;

    int checks = 0;
    int errors = 0;
    step_t q[$];

    multicycle_control #(
        .INSTR_W    (32),
        .ALU_OP_W   (4),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .instr_ready(instr_ready),
        .mem_ready  (mem_ready),
        .instr_req  (instr_req),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_dst    (reg_dst),
        .jump       (jump),
        .branch     (branch),
        .mem_read   (mem_read),
        .mem_to_reg (mem_to_reg),
        .mem_write  (mem_write),
        .alu_src    (alu_src),
        .reg_write  (reg_write),
        .alu_op     (alu_op),
        .illegal_op (illegal_op),
        .mem_err    (mem_err),
        .retire     (retire),
        .state_dbg  (state_dbg)
    );

    assign obs = {instr_req, ir_write, pc_write, reg_dst, jump, branch, mem_read,
                  mem_to_reg, mem_write, alu_src, reg_write, alu_op, illegal_op,
                  mem_err, retire, state_dbg};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b001110, 6'b001111, 6'b100100,
                          6'b100110, 6'b001100, 6'b000100};
    endfunction

    task automatic push(input vec_t v, input logic r, input logic m, input logic [31:0] ins);
        step_t s;
        s.exp = v; s.rdy = r; s.mrdy = m; s.ins = ins;
        q.push_back(s);
    endtask

    // Cycle where the handshakes must not matter: drive them randomly
    task automatic push_x(input vec_t v);
        push(v, 1'($urandom), 1'($urandom), $urandom);
    endtask

    task automatic push_wb(input logic rd, input logic m2r);
        vec_t v;
        v = '0; v.state = 3'd5; v.reg_write = 1'b1; v.pc_write = 1'b1;
        v.retire = 1'b1; v.reg_dst = rd; v.mem_to_reg = m2r;
        push_x(v);
    endtask

    // Expected trace of one instruction; mwait >= MEM_TIMEOUT means mem_ready never comes
    task automatic build(input logic [31:0] ins, input int fwait, input int mwait);
        vec_t v, vm;
        logic [5:0] op;
        bit lw;
        op = ins[31:26];
        for (int i = 0; i < fwait; i++) begin
            v = '0; v.instr_req = 1'b1; v.state = 3'd1;
            push(v, 1'b0, 1'($urandom), $urandom);
        end
        v = '0; v.instr_req = 1'b1; v.ir_write = 1'b1; v.state = 3'd1;
        push(v, 1'b1, 1'($urandom), ins);
        v = '0; v.state = 3'd2;
        if (!is_legal(op)) begin
            v.illegal_op = 1'b1; v.pc_write = 1'b1;
            push_x(v);
            return;
        end
        push_x(v);
        v = '0; v.state = 3'd3;
        case (op)
            6'b000000: begin v.alu_op = ins[3:0]; v.reg_dst = 1'b1; push_x(v); push_wb(1'b1, 1'b0); end
            6'b001110: begin v.alu_op = 4'd2; v.alu_src = 1'b1; push_x(v); push_wb(1'b0, 1'b0); end
            6'b001111: begin v.alu_src = 1'b1; push_x(v); push_wb(1'b0, 1'b0); end
            6'b001100: begin v.alu_op = 4'd6; v.branch = 1'b1; v.pc_write = 1'b1; v.retire = 1'b1; push_x(v); end
            6'b000100: begin v.jump = 1'b1; v.pc_write = 1'b1; v.retire = 1'b1; push_x(v); end
            default: begin
                lw = (op == 6'b100100);
                v.alu_op = 4'd2; v.alu_src = 1'b1; push_x(v);
                vm = '0; vm.state = 3'd4; vm.alu_op = 4'd2; vm.alu_src = 1'b1;
                vm.mem_read = lw; vm.mem_write = !lw;
                if (mwait < int'(MEM_TIMEOUT)) begin
                    for (int i = 0; i < mwait; i++) push(vm, 1'($urandom), 1'b0, $urandom);
                    v = vm;
                    if (!lw) begin v.pc_write = 1'b1; v.retire = 1'b1; end
                    push(v, 1'($urandom), 1'b1, $urandom);
                    if (lw) push_wb(1'b0, 1'b1);
                end else begin
                    for (int i = 0; i < int'(MEM_TIMEOUT) - 1; i++) push(vm, 1'($urandom), 1'b0, $urandom);
                    v = vm; v.mem_err = 1'b1; v.pc_write = 1'b1;
                    push(v, 1'($urandom), 1'b0, $urandom);
                end
            end
        endcase
    endtask

    task automatic run_steps(input string tag, input int n);
        step_t s;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            s = q.pop_front();
            @(negedge clk);
            instr = s.ins; instr_ready = s.rdy; mem_ready = s.mrdy;
            #1;
            checks++;
            assert (obs === s.exp) else begin
                errors++;
                $error("FAIL %s step %0d observed=%h expected=%h", tag, i, obs, s.exp);
            end
        end
    endtask

    task automatic run_instr(input string tag, input logic [31:0] ins, input int fw, input int mw);
        build(ins, fw, mw);
        run_steps(tag, q.size());
    endtask

    task automatic check_vec(input string tag, input vec_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [5:0] legal_ops [7];
    logic [5:0] op;

    initial begin
        legal_ops = '{6'b000000, 6'b001110, 6'b001111, 6'b100100,
                      6'b100110, 6'b001100, 6'b000100};
        rst_n = 1'b0; instr = 32'hFFFF_FFFF; instr_ready = 1'b1; mem_ready = 1'b1;
        @(negedge clk); #1;
        check_vec("reset_hold", '0);
        @(negedge clk);
        rst_n = 1'b1; instr_ready = 1'b0; mem_ready = 1'b0;
        #1;
        check_vec("post_reset_idle", '0);

        run_instr("rtype_5",     32'h0000_0005, 0, 0);
        run_instr("lw_wait3",    32'h9000_0000, 0, 3);
        run_instr("sw_timeout",  32'h9800_0000, 0, 1000);
        run_instr("illegal_3f",  32'hFC00_0000, 0, 0);
        run_instr("sw_last_rdy", 32'h9800_1234, 2, int'(MEM_TIMEOUT) - 1);
        run_instr("lw_last_rdy", 32'h9000_0042, 0, int'(MEM_TIMEOUT) - 1);
        run_instr("branch",      32'h3000_00FF, 1, 0);
        run_instr("jump",        32'h1000_0ABC, 0, 0);
        run_instr("addi",        32'h3800_0007, 3, 0);
        run_instr("passi",       32'h3C00_000F, 0, 0);
        run_instr("rtype_f",     32'h03FF_FFFF, 0, 0);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 6)];
            else op = 6'($urandom);
            run_instr("random", {op, 26'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 20));
        end

        // Reset asserted while a load waits in MEM
        build(32'h9000_0000, 0, 1000);
        run_steps("rst_lw_pre", 5);
        checks++;
        assert (mem_read === 1'b1) else begin
            errors++;
            $error("FAIL rst_lw_mem_read observed=%b expected=1", mem_read);
        end
        #2 rst_n = 1'b0;
        #1;
        check_vec("async_rst_mid_mem", '0);
        q.delete();
        @(negedge clk); #1;
        check_vec("rst_hold_2", '0);
        @(negedge clk);
        rst_n = 1'b1; instr_ready = 1'b0; mem_ready = 1'b0;
        #1;
        check_vec("rst2_idle", '0);
        run_instr("lw_timeout_after_rst", 32'h9000_0000, 1, 1000);
        run_instr("rtype_after", 32'h0000_0003, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Parametrised multi-cycle control unit for the MIPS-style core. It replaces single-cycle opcode decoding with a sequencing FSM that fetches an instruction over a ready handshake, latches it into an internal instruction register, and steps through DECODE/EXEC/MEM/WB. It drives the datapath control strobes per state. It also stalls on a data-memory handshake, with a bounded timeout, and flags illegal opcodes.

Parameters:
INSTR_W, 32, instruction width; opcode is IR[INSTR_W-1 -: 6].
ALU_OP_W, 4, ALU op width; legal range 4..6; R-type function field is IR[ALU_OP_W-1:0].
MEM_TIMEOUT, 15, maximum MEM wait cycles before abort; must be >= 1.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr  in  INSTR_W  instruction from instruction memory
instr_ready  in  1  instr valid this cycle (FETCH handshake)
mem_ready  in  1  data memory completed access this cycle
instr_req  out  1  instruction fetch request
ir_write  out  1  IR load strobe (pulse)
pc_write  out  1  PC update strobe (pulse)
reg_dst  out  1  write-register select = rd
jump  out  1  jump PC select
branch  out  1  branch compare enable
mem_read  out  1  data memory read request
mem_to_reg  out  1  writeback from memory
mem_write  out  1  data memory write request
alu_src  out  1  ALU B = immediate
reg_write  out  1  register file write enable
alu_op  out  ALU_OP_W  ALU operation
illegal_op  out  1  undefined opcode (pulse)
mem_err  out  1  MEM timeout abort (pulse)
retire  out  1  instruction completed (pulse, coincident with pc_write)
state_dbg  out  3  encoded current state

Behaviour:
- Reset is asynchronous: state goes to IDLE, IR=0, timeout counter=0, and every output is 0 immediately. This includes reset asserted mid-instruction; no strobe may survive it.
- Outputs are decoded combinationally from the registered state and IR only. There is no combinational path from instr, instr_ready or mem_ready to outputs, except ir_write and the FETCH/MEM exit strobes listed below.
- State encoding (state_dbg): IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.
- IDLE: all outputs 0; go to FETCH next cycle.
- FETCH: instr_req=1. When instr_ready=1: ir_write=1, IR<=instr, go to DECODE. Otherwise hold with no timeout.
- DECODE: one cycle with all strobes 0.
  - Defined opcodes go to EXEC.
  - Any other opcode: illegal_op=1, pc_write=1, retire=0, go to FETCH.
- EXEC, by opcode:
  - 000000 R-type: alu_op=IR[ALU_OP_W-1:0], reg_dst=1; go to WB.
  - 001110 add-immediate: alu_op=2, alu_src=1; go to WB.
  - 001111 pass-immediate: alu_op=0, alu_src=1; go to WB.
  - 100100 lw: alu_op=2, alu_src=1; go to MEM.
  - 100110 sw: alu_op=2, alu_src=1; go to MEM.
  - 001100 branch: alu_op=6, branch=1, pc_write=1, retire=1; go to FETCH.
  - 000100 jump: jump=1, pc_write=1, retire=1; go to FETCH.
- MEM: alu_op=2 and alu_src=1 held; mem_read=1 (lw) or mem_write=1 (sw) held every cycle.
  - Timeout counter increments each MEM cycle without mem_ready and clears on MEM entry.
  - mem_ready=1: lw goes to WB; sw asserts pc_write=1 and retire=1 in that cycle and goes to FETCH.
  - Counter reaching MEM_TIMEOUT without mem_ready: mem_err=1, pc_write=1, retire=0, go to FETCH.
  - mem_ready in the same cycle the counter reaches MEM_TIMEOUT: mem_ready wins and no mem_err is raised.
- WB: reg_write=1, pc_write=1, retire=1; go to FETCH.
  - R-type: reg_dst=1.
  - lw: mem_to_reg=1.
- Latency with zero-wait handshakes, counted from the first FETCH cycle:
  - R-type, add-immediate, pass-immediate: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - branch, jump: 3 cycles.
  - illegal: 2 cycles.
- Strobes ir_write, pc_write, retire, illegal_op and mem_err are single-cycle pulses per instruction.

Test Plan:
- Reset release: rst_n low then high. All outputs 0 during reset; state_dbg 0, then 1 on the next edge; instr_req=1.
- R-type: instr=0x00000005 with instr_ready=1. ir_write pulses; EXEC shows alu_op=5, reg_dst=1; WB shows reg_write=1, pc_write=1, retire=1; back in FETCH 4 cycles after the first FETCH.
- lw with 3-cycle mem_ready delay (instr=0x90000000): mem_read held for 4 MEM cycles; WB shows mem_to_reg=1, reg_write=1; total 8 cycles.
- sw with mem_ready never asserted, MEM_TIMEOUT=15: mem_write high for 15 cycles, then mem_err=1 and pc_write=1, retire=0, reg_write never asserted.
- Illegal opcode 0x3F: illegal_op=1 and pc_write=1 in DECODE, no other strobes; FETCH the next cycle.
- rst_n dropped during MEM of lw: mem_read goes to 0 asynchronously before the next edge; after release, state is IDLE then FETCH, and the timeout counter restarts from 0 on the next MEM entry.
